// File: rtl/mem_responder.sv
// mem_responder
//   Responder for a single-port byte memory bus. It holds a 2**ADDR_WIDTH x
//   DATA_WIDTH array. Writes complete in one cycle. Reads return through a
//   pipeline of RD_LATENCY stages and raise a one-cycle valid_out strobe.
//   After every reset the block zero-fills the whole array. While that sweep
//   runs, busy is high, requests are dropped, and drop_cnt counts them.
//
// Ports
//   clk        system clock, all state updates on posedge
//   reset_n    asynchronous active-low reset
//   data_in    write data
//   addr       read/write address
//   we         write request
//   read_en    read request
//   data_out   read data, meaningful when valid_out=1, otherwise holds last read
//   valid_out  one-cycle strobe per completed read
//   busy       zero-fill sweep in progress
//   drop_cnt   saturating count of requests dropped while busy
module mem_responder #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int DROP_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  busy,
  output logic [DROP_W-1:0]     drop_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("mem_responder: RD_LATENCY must be in the range 1..4");
    end
  endgenerate

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  // Read pipeline: stage i holds a read accepted i edges earlier.
  // The last stage drives the outputs.
  logic [RD_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];

  // Control state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      sweep_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Next state, array write port selection, read acceptance
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    mem_we      = 1'b0;
    mem_waddr   = addr;
    mem_wdata   = data_in;
    rd_acc      = 1'b0;
    case (state_q)
      INIT: begin
        // The sweep owns the write port. Bus requests are discarded and counted.
        mem_we      = 1'b1;
        mem_waddr   = sweep_cnt_q;
        mem_wdata   = '0;
        sweep_cnt_d = sweep_cnt_q + ADDR_WIDTH'(1);
        if (&sweep_cnt_q) begin
          state_d = READY;
        end
        if ((we || read_en) && !(&drop_cnt_q)) begin
          drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
      end
      READY: begin
        mem_we = we;
        rd_acc = read_en;
      end
      default: state_d = INIT;
    endcase
  end

  // Write-first: a read that coincides with a write returns the new data.
  assign rd_data = we ? data_in : mem[addr];

  // Array storage. It has no reset; the sweep clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Stage 0 captures the read at the request edge. Each later stage captures
  // only when a valid read arrives. The final stage therefore holds the last
  // read value between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) begin
        dat_q[0] <= rd_data;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign valid_out = vld_q[RD_LATENCY-1];
  assign data_out  = dat_q[RD_LATENCY-1];
  assign busy      = (state_q == INIT);
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. Three instances with RD_LATENCY 1, 2 and 3
// share one stimulus stream. All three are compared every cycle against a
// reference model. The model holds the memory as an array and a countdown of
// sweep edges, and it records accepted reads with the edge at which they were
// taken.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  data_in = '0;
  logic [10:0] addr = '0;
  logic        we = 1'b0;
  logic        read_en = 1'b0;

  logic [7:0] d1, d2, d3, c1, c2, c3;
  logic       v1, v2, v3, b1, b2, b3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.RD_LATENCY(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .addr(addr), .we(we),
    .read_en(read_en), .data_out(d1), .valid_out(v1), .busy(b1), .drop_cnt(c1));
  mem_responder #(.RD_LATENCY(2)) u_lat2 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .addr(addr), .we(we),
    .read_en(read_en), .data_out(d2), .valid_out(v2), .busy(b2), .drop_cnt(c2));
  mem_responder #(.RD_LATENCY(3)) u_lat3 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .addr(addr), .we(we),
    .read_en(read_en), .data_out(d3), .valid_out(v3), .busy(b3), .drop_cnt(c3));

  // Reference model state
  logic [7:0] m_mem [2048];
  int         busy_left;
  int         m_drop;
  int         edge_t = 0;
  bit         hv [8];
  int         ht [8];
  logic [7:0] hd [8];
  bit         ev [1:3];
  logic [7:0] ed [1:3];

  task automatic model_reset();
    busy_left = 2048;
    m_drop    = 0;
    for (int i = 0; i < 8; i++) hv[i] = 1'b0;
    for (int l = 1; l <= 3; l++) begin ev[l] = 1'b0; ed[l] = 8'h00; end
    // Reads are blocked until the sweep has finished, so a reader sees all zeros.
    for (int i = 0; i < 2048; i++) m_mem[i] = 8'h00;
  endtask

  task automatic model_step();
    int s;
    edge_t++;
    s = edge_t % 8;
    hv[s] = 1'b0;
    if (busy_left > 0) begin
      if (we || read_en) m_drop = (m_drop == 255) ? 255 : m_drop + 1;
      busy_left--;
    end else begin
      if (we) m_mem[addr] = data_in;
      if (read_en) begin
        hv[s] = 1'b1; ht[s] = edge_t; hd[s] = m_mem[addr];
      end
    end
    // With latency L, a read taken at edge e completes at edge e+L-1.
    for (int l = 1; l <= 3; l++) begin
      int e;
      e = edge_t - l + 1;
      if (e > 0 && hv[e % 8] && ht[e % 8] == e) begin
        ev[l] = 1'b1; ed[l] = hd[e % 8];
      end else begin
        ev[l] = 1'b0;
      end
    end
  endtask

  function automatic logic [53:0] obs();
    return {v1, d1, b1, c1, v2, d2, b2, c2, v3, d3, b3, c3};
  endfunction

  function automatic logic [53:0] expv();
    logic       eb;
    logic [7:0] ec;
    eb = (busy_left > 0);
    ec = 8'(m_drop);
    return {ev[1], ed[1], eb, ec, ev[2], ed[2], eb, ec, ev[3], ed[3], eb, ec};
  endfunction

  // One bus cycle, entered and left at a negedge.
  task automatic cyc(input logic w, input logic r, input logic [10:0] a, input logic [7:0] d);
    we = w; read_en = r; addr = a; data_in = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    we = 1'b0; read_en = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    if ({v1, d1, b1, c1} !== {1'b0, 8'h00, 1'b1, 8'h00}) begin
      errors++; $display("FAIL reset_state got %h exp %h", {v1, d1, b1, c1}, {1'b0, 8'h00, 1'b1, 8'h00});
    end
    checks++;
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 3000 && b1 === 1'b1; i++) begin
      n++;
      cyc(1'b0, 1'b0, 11'h000, 8'h00);
      if (obs() !== expv()) begin errors++; $display("FAIL sweep got %h exp %h", obs(), expv()); end
      checks++;
    end
    if (n !== 2048) begin errors++; $display("FAIL busy_len got %0d exp 2048", n); end
    checks++;
    cyc(1'b0, 1'b1, 11'h7FF, 8'h00);
    if ({v1, d1} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL read_7ff got %h exp %h", {v1, d1}, {1'b1, 8'h00});
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 11'h000, 8'h00);
      if (obs() !== expv()) begin errors++; $display("FAIL read_7ff_tail got %h exp %h", obs(), expv()); end
      checks++;
    end
  endtask

  task automatic test_write_read();
    cyc(1'b1, 1'b0, 11'h123, 8'hA5);
    if (obs() !== expv()) begin errors++; $display("FAIL wr_a5 got %h exp %h", obs(), expv()); end
    checks++;
    cyc(1'b0, 1'b1, 11'h123, 8'h00);
    if ({v1, d1} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL rd_lat1 got %h exp %h", {v1, d1}, {1'b1, 8'hA5}); end
    checks++;
    if (v3 !== 1'b0) begin errors++; $display("FAIL rd_lat3_early got %b exp 0", v3); end
    checks++;
    cyc(1'b0, 1'b0, 11'h000, 8'h00);
    if ({v1, v2, d2} !== {1'b0, 1'b1, 8'hA5}) begin
      errors++; $display("FAIL rd_lat2 got %h exp %h", {v1, v2, d2}, {1'b0, 1'b1, 8'hA5});
    end
    checks++;
    cyc(1'b0, 1'b0, 11'h000, 8'h00);
    if ({v3, d3} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL rd_lat3 got %h exp %h", {v3, d3}, {1'b1, 8'hA5}); end
    checks++;
    cyc(1'b0, 1'b0, 11'h000, 8'h00);
    if (obs() !== expv()) begin errors++; $display("FAIL rd_hold got %h exp %h", obs(), expv()); end
    checks++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 11'(i), 8'(8'h11 * (i + 1)));
      if (obs() !== expv()) begin errors++; $display("FAIL b2b_wr got %h exp %h", obs(), expv()); end
      checks++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 11'(i), 8'h00);
      if ({v1, d1} !== {1'b1, 8'(8'h11 * (i + 1))}) begin
        errors++; $display("FAIL b2b_rd%0d got %h exp %h", i, {v1, d1}, {1'b1, 8'(8'h11 * (i + 1))});
      end
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL b2b_all got %h exp %h", obs(), expv()); end
      checks++;
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 11'h000, 8'h00);
      if (obs() !== expv()) begin errors++; $display("FAIL b2b_tail got %h exp %h", obs(), expv()); end
      checks++;
    end
  endtask

  task automatic test_write_first();
    cyc(1'b1, 1'b1, 11'h050, 8'h5A);
    if ({v1, d1} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL wf_same got %h exp %h", {v1, d1}, {1'b1, 8'h5A}); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 11'h000, 8'h00);
      if (obs() !== expv()) begin errors++; $display("FAIL wf_tail got %h exp %h", obs(), expv()); end
      checks++;
    end
    cyc(1'b0, 1'b1, 11'h050, 8'h00);
    if ({v1, d1} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL wf_later got %h exp %h", {v1, d1}, {1'b1, 8'h5A}); end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom % 2), 1'($urandom % 2), 11'($urandom_range(0, 31)), 8'($urandom));
      if (obs() !== expv()) begin errors++; $display("FAIL random got %h exp %h", obs(), expv()); end
      checks++;
    end
  endtask

  task automatic test_drop();
    logic [10:0] seen [4];
    logic        w, r;
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    if (obs() !== expv()) begin errors++; $display("FAIL drop_reset got %h exp %h", obs(), expv()); end
    checks++;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [10:0] a;
      r = 1'($urandom % 2);
      w = r ? 1'($urandom % 2) : 1'b1;
      a = (i < 4) ? 11'(i * 8) : 11'($urandom_range(0, 2047));
      if (i < 4) begin w = 1'b1; seen[i] = a; end
      cyc(w, r, a, 8'($urandom_range(1, 255)));
      if (obs() !== expv()) begin errors++; $display("FAIL drop_busy got %h exp %h", obs(), expv()); end
      checks++;
    end
    if ({c1, c2, c3} !== {8'hFF, 8'hFF, 8'hFF}) begin
      errors++; $display("FAIL drop_sat got %h exp %h", {c1, c2, c3}, 24'hFFFFFF);
    end
    checks++;
    for (int i = 0; i < 3000 && busy_left > 0; i++) begin
      cyc(1'b0, 1'b0, 11'h000, 8'h00);
      if (obs() !== expv()) begin errors++; $display("FAIL drop_sweep got %h exp %h", obs(), expv()); end
      checks++;
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, seen[i], 8'h00);
      if ({v1, d1} !== {1'b1, 8'h00}) begin
        errors++; $display("FAIL drop_nowrite got %h exp %h", {v1, d1}, {1'b1, 8'h00});
      end
      checks++;
    end
    cyc(1'b0, 1'b1, 11'h123, 8'h00);
    if ({v1, d1} !== {1'b1, 8'h00}) begin errors++; $display("FAIL drop_swept got %h exp %h", {v1, d1}, {1'b1, 8'h00}); end
    checks++;
  endtask

  task automatic test_reset_midflight();
    int n;
    cyc(1'b1, 1'b0, 11'h010, 8'h77);
    cyc(1'b1, 1'b0, 11'h011, 8'h88);
    cyc(1'b0, 1'b1, 11'h010, 8'h00);
    cyc(1'b0, 1'b1, 11'h011, 8'h00);
    if ({v2, d2, v3} !== {1'b1, 8'h77, 1'b0}) begin
      errors++; $display("FAIL inflight got %h exp %h", {v2, d2, v3}, {1'b1, 8'h77, 1'b0});
    end
    checks++;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    if (obs() !== {1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00}) begin
      errors++; $display("FAIL midreset got %h exp %h", obs(), expv());
    end
    checks++;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 3000 && b2 === 1'b1; i++) begin
      n++;
      cyc(1'b0, 1'b0, 11'h000, 8'h00);
      if (obs() !== expv()) begin errors++; $display("FAIL resweep got %h exp %h", obs(), expv()); end
      checks++;
    end
    if (n !== 2048) begin errors++; $display("FAIL rebusy_len got %0d exp 2048", n); end
    checks++;
    cyc(1'b0, 1'b1, 11'h011, 8'h00);
    cyc(1'b0, 1'b0, 11'h000, 8'h00);
    if ({v2, d2} !== {1'b1, 8'h00}) begin errors++; $display("FAIL post_reset_rd got %h exp %h", {v2, d2}, {1'b1, 8'h00}); end
    checks++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_write_first();
    test_random();
    test_drop();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
